// File: rtl/arty_reset_pkg.sv
// Shared types and limits for the Arty A7 reset sequencer.
package arty_reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } t_rst_seq_state;

    localparam int c_RST_SYNC_MIN     = 2;
    localparam int c_RST_CHANNELS_MAX = 16;

    // Bit width needed to hold values 0..value-1, never less than one bit.
    function automatic int f_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/arty_reset_sequencer_if.sv
// Software-facing side of the reset sequencer: request in, per-channel resets and done out.
interface arty_reset_sequencer_if #(
    parameter int CHANNELS = 3
);
    // i_sw_rst_req is a plain level, sampled on every clock edge, with no handshake.
    // Each cycle it is high forces all channels back into reset. o_rst_mhz and
    // o_rst_done are registered levels that consumers may sample on any edge.
    logic                i_sw_rst_req;
    logic [CHANNELS-1:0] o_rst_mhz;
    logic                o_rst_done;

    modport master (
        output i_sw_rst_req,
        input  o_rst_mhz,
        input  o_rst_done
    );

    modport slave (
        input  i_sw_rst_req,
        output o_rst_mhz,
        output o_rst_done
    );
endinterface

// File: rtl/arty_reset_sync_chain.sv
// Multi-flop synchronizer with asynchronous active-low reset to a chosen level.
module arty_reset_sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_sync
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/arty_reset_sequencer.sv
// Reset sequencer: synchronized release of CHANNELS reset domains in index order.
// Define RST_SEQ_MMCM_LOCK_EN to add the i_mmcm_locked input and lock-loss abort.
module arty_reset_sequencer
    import arty_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int CHANNELS    = 3,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                         i_clk_mhz,
    input  logic                         i_rstn_global,
`ifdef RST_SEQ_MMCM_LOCK_EN
    input  logic                         i_mmcm_locked,
`endif
    arty_reset_sequencer_if.slave        bus,
    output t_rst_seq_state               o_dbg_state
);

    localparam int SYNC_DEPTH = (SYNC_STAGES < c_RST_SYNC_MIN) ? c_RST_SYNC_MIN : SYNC_STAGES;
    localparam int CNT_MAX    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = f_width(CNT_MAX);
    localparam int IDX_W      = f_width(CHANNELS);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);

    logic s_rst_sync;
    logic lock_ok;
    logic abort_d;

    t_rst_seq_state      state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CHANNELS-1:0] rst_q;
    logic                done_q;

    arty_reset_sync_chain #(
        .STAGES    (SYNC_DEPTH),
        .RESET_VAL (1'b1)
    ) u_rst_sync (
        .i_clk  (i_clk_mhz),
        .i_rstn (i_rstn_global),
        .i_d    (1'b0),
        .o_sync (s_rst_sync)
    );

`ifdef RST_SEQ_MMCM_LOCK_EN
    // Lock is treated as lost until it has been seen through the synchronizer.
    arty_reset_sync_chain #(
        .STAGES    (SYNC_DEPTH),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .i_clk  (i_clk_mhz),
        .i_rstn (i_rstn_global),
        .i_d    (i_mmcm_locked),
        .o_sync (lock_ok)
    );
`else
    assign lock_ok = 1'b1;
`endif

    assign abort_d = bus.i_sw_rst_req | ~lock_ok;

    always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
        if (!i_rstn_global) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LOAD;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else if (abort_d) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LOAD;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (s_rst_sync) begin
                        cnt_q <= HOLD_LOAD;
                    end else if (cnt_q == '0) begin
                        rst_q[0] <= 1'b0;
                        if (CHANNELS == 1) begin
                            done_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            cnt_q   <= GAP_LOAD;
                            idx_q   <= IDX_W'(1);
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == '0) begin
                        rst_q[idx_q] <= 1'b0;
                        idx_q        <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            cnt_q <= GAP_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= HOLD_LOAD;
                end
            endcase
        end
    end

    assign bus.o_rst_mhz  = rst_q;
    assign bus.o_rst_done = done_q;
    assign o_dbg_state    = state_q;

endmodule

// File: doc/arty_reset_sequencer.md
# arty_reset_sequencer

Parametrised reset sequencer for the Arty A7 single-clock design. It applies an asynchronous-assert, synchronous-deassert reset to `CHANNELS` downstream reset domains. After the synchronized reset and a minimum hold time, it releases the channels one at a time in index order, spaced `GAP_CYCLES` apart. It also re-asserts all channels on a software reset request and, optionally, on MMCM lock loss. It sits directly behind the board reset pin and replaces the fixed 14-stage shifter in the top level.

## Interface
- `SYNC_STAGES`, default 2: deassert synchronizer depth; legal range 2..8.
- `HOLD_CYCLES`, default 1024: cycles all channels stay asserted after synchronized deassert; range 1..65535.
- `CHANNELS`, default 3: number of reset outputs; range 1..16.
- `GAP_CYCLES`, default 16: cycles between successive channel releases; range 1..65535.
- `i_clk_mhz`  in  1: system clock.
- `i_rstn_global`  in  1: reset, asynchronous, active-low; clock `i_clk_mhz`.
- `i_mmcm_locked`  in  1: MMCM lock, asynchronous level. Present only with `RST_SEQ_MMCM_LOCK_EN`.
- `i_sw_rst_req`  in  1: synchronous software reset request, sampled each edge.
- `o_rst_mhz`  out  CHANNELS: active-high per-channel resets, registered.
- `o_rst_done`  out  1: high once all channels are released, registered.

## Operation
- Reset values: `o_rst_mhz` = all ones; `o_rst_done` = 0; FSM = `ST_HOLD`; counter = `HOLD_CYCLES-1`.
- Assertion of `i_rstn_global` low:
  - Drives all outputs to their reset values asynchronously, with no clock required.
  - This applies in every state, including mid-sequence.
- Deassert path: a `SYNC_STAGES`-deep shift chain, async-set to 1 and shifting in 0, produces `s_rst_sync`.
- Lock handling:
  - `lock_ok` is `i_mmcm_locked` passed through a `SYNC_STAGES`-flop synchronizer when the macro is defined.
  - Otherwise `lock_ok` is constant 1.
- `ST_HOLD`:
  - While `s_rst_sync` = 1 or `lock_ok` = 0, the counter reloads to `HOLD_CYCLES-1`.
  - Otherwise the counter decrements by 1 per cycle.
  - At counter = 0: clear `o_rst_mhz[0]`, load the counter with `GAP_CYCLES-1`, set channel index = 1, and go to `ST_RELEASE`.
  - If `CHANNELS` = 1, go to `ST_RUN` instead and set `o_rst_done`.
- `ST_RELEASE`:
  - The counter decrements each cycle.
  - At 0: clear `o_rst_mhz[index]` and increment index.
  - If that was the last channel, set `o_rst_done` and go to `ST_RUN`; otherwise reload `GAP_CYCLES-1`.
- `ST_RUN`: idle; outputs are stable.
- Abort, checked in any state and taking priority over counting:
  - Triggered by `i_sw_rst_req` = 1 or `lock_ok` = 0.
  - On the next edge: all `o_rst_mhz` go to 1, `o_rst_done` goes to 0, FSM goes to `ST_HOLD`, counter reloads.
  - A held `i_sw_rst_req` keeps the FSM in `ST_HOLD`. The hold count restarts after the request drops.
- Released channels never re-deassert out of order. The release order is always 0, 1, …, CHANNELS-1.
- Counter width is `$clog2(max(HOLD_CYCLES, GAP_CYCLES))`, minimum 1, unsigned. It never wraps, because each state reloads it on reaching 0.

## Timing
- Edge numbering: edge 1 is the first `i_clk_mhz` rising edge at which `i_rstn_global` is high, with recovery met.
- `s_rst_sync` falls after edge `SYNC_STAGES`.
- `o_rst_mhz[k]` falls after edge `SYNC_STAGES + HOLD_CYCLES + k*GAP_CYCLES`.
- `o_rst_done` rises on the same edge as `o_rst_mhz[CHANNELS-1]` falls.
- `i_sw_rst_req` sampled high at edge n: all outputs high after edge n.
- Lock loss (macro defined): `i_mmcm_locked` falling before edge n gives all outputs high after edge `n + SYNC_STAGES`.
- A lock glitch shorter than one cycle may be missed. This is accepted, because the MMCM lock is a level signal.

## Configuration
- Macro `RST_SEQ_MMCM_LOCK_EN`.
- Defined:
  - The `i_mmcm_locked` port and its synchronizer exist.
  - The hold countdown is gated on lock, and lock loss aborts to `ST_HOLD`.
- Undefined:
  - No lock port; `lock_ok` = 1.
  - Behaviour is identical otherwise.

## Structure
- Package `arty_reset_pkg`:
  - Holds the FSM enum `t_rst_seq_state {ST_HOLD, ST_RELEASE, ST_RUN}`.
  - Holds the limit constants `c_RST_SYNC_MIN` = 2 and `c_RST_CHANNELS_MAX` = 16.
- Sub-module `arty_reset_sync_chain`:
  - Parameter `STAGES`, input clock, async active-low reset input, output `o_sync`.
  - Instantiated once for the reset path.
  - A second instance, with data input variant `i_d`, serves the lock path.

## Test plan
- Power-on release, `SYNC_STAGES`=3, `HOLD_CYCLES`=8, `GAP_CYCLES`=4, `CHANNELS`=3: `o_rst_mhz[0]` falls after edge 11, `[1]` after 15, `[2]` after 19. `o_rst_done` rises after 19.
- Async reset mid-`ST_RELEASE`, with `i_rstn_global` pulled low between edges 16 and 17: all outputs go to 1 within the same cycle, before edge 17. On release, the full sequence repeats with the same edge counts.
- Software reset: `i_sw_rst_req` is high for 1 cycle at edge 30 in `ST_RUN`. All outputs are 1 after edge 30; `o_rst_done` = 0. `o_rst_mhz[0]` falls after edge 38 and `o_rst_done` rises after edge 46.
- Held software reset: `i_sw_rst_req` is high for edges 30..40. Outputs stay asserted; `o_rst_mhz[0]` falls after edge 48.
- Lock loss (macro defined, `SYNC_STAGES`=3): `i_mmcm_locked` drops before edge 30 in `ST_RUN`, giving all outputs high after edge 33. Lock returns before edge 50, so `lock_ok` rises after edge 52 and `o_rst_mhz[0]` falls after edge 60.
- `CHANNELS`=1, macro undefined, `HOLD_CYCLES`=1, `SYNC_STAGES`=2: `o_rst_mhz[0]` falls and `o_rst_done` rises together after edge 3.
